// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {FILL, RUN, MEM_WAIT} state_t;

  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_RF = 2'b00;
  localparam fwd_t FWD_W  = 2'b01;
  localparam fwd_t FWD_M  = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // M is the younger producer, so its result wins over W
  function automatic fwd_t fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && rd_m != REG_X0 && rd_m == rs) return FWD_M;
    if (we_w && rd_w != REG_X0 && rd_w == rs) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational operand forwarding select for the Execute stage
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward control with post-reset fill and memory wait
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FILL_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               load_use;

  forward_unit u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  assign load_use = ResultSrcE && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    case (state_q)
      FILL: begin
        StallF = 1'b1;
        FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
        if (fill_cnt_q == '0) state_d = RUN;
        else                  fill_cnt_d = fill_cnt_q - FILL_W'(1);
      end
      RUN: begin
        // A miss freezes the pipe in the same cycle it is seen
        if (MemReqM && !MemReadyM) begin
          StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
          FlushW = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (PCSrcE) begin
          FlushD = 1'b1; FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
        FlushW = 1'b1;
        if (MemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_err_d  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = FILL;
    endcase
    stall_count_d = (StallF && stall_count_q != '1) ? stall_count_q + CNT_W'(1) : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      fill_cnt_q    <= FILL_LAST;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_err     = mem_err_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [15:0] stall_count;
  logic [7:0]  ctrl;

  int vectors = 0;
  int miscompares = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  localparam logic [7:0] C_FILL = 8'b1000_1111;
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_1100;
  localparam logic [7:0] C_FRZ  = 8'b1111_0001;

  pipeline_hazard_ctrl #(.FILL_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check("reset_ctrl", 32'(ctrl), 32'(C_FILL));
    check("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'(4'b0000));
    check("reset_mem_err", 32'(mem_err), 32'(1'b0));
    check("reset_stall_count", 32'(stall_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Fill: branch input must be ignored
    PCSrcE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fill_ctrl_%0d", i), 32'(ctrl), 32'(C_FILL));
      tick();
    end
    PCSrcE = 1'b0;
    #1;
    check("fill_done_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("fill_stall_count", 32'(stall_count), 32'd4);

    // Load-use on Rs1D, then x0 destination, then Rs2D
    ResultSrcE = 1; RdE = 5; Rs1D = 5;
    #1 check("lu_rs1", 32'(ctrl), 32'(C_LU));
    tick();
    RdE = 0;
    #1 check("lu_x0", 32'(ctrl), 32'(C_IDLE));
    tick();
    check("lu_count", 32'(stall_count), 32'd5);
    Rs1D = 0; Rs2D = 9; RdE = 9;
    #1 check("lu_rs2", 32'(ctrl), 32'(C_LU));
    tick();
    ResultSrcE = 0;
    #1 check("no_load", 32'(ctrl), 32'(C_IDLE));
    tick();

    // Branch overrides load-use
    ResultSrcE = 1; RdE = 5; Rs1D = 5; PCSrcE = 1;
    #1 check("br_over_lu", 32'(ctrl), 32'(C_BR));
    tick();
    check("br_count", 32'(stall_count), 32'd6);
    idle_inputs();

    // Forwarding priority
    RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 3;
    #1 check("fwd_a_m", 32'(ForwardAE), 32'(2'b10));
    check("fwd_b_none", 32'(ForwardBE), 32'(2'b00));
    RegWriteM = 0;
    #1 check("fwd_a_w", 32'(ForwardAE), 32'(2'b01));
    Rs2E = 0; RdW = 0;
    #1 check("fwd_b_x0", 32'(ForwardBE), 32'(2'b00));
    check("fwd_a_rdw0", 32'(ForwardAE), 32'(2'b00));
    RegWriteM = 1; RdM = 12; RdW = 12; Rs2E = 12;
    #1 check("fwd_b_m", 32'(ForwardBE), 32'(2'b10));
    tick();
    idle_inputs();

    // Memory wait: 3 not-ready cycles then ready; branch ignored while frozen
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReadyM = 1;
      #1 check($sformatf("mw_ctrl_%0d", i), 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    idle_inputs();
    #1 check("mw_exit_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("mw_mem_err", 32'(mem_err), 32'(1'b0));
    check("mw_count", 32'(stall_count), 32'd10);

    // Timeout: 1 RUN cycle + 16 MEM_WAIT cycles without ready
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 16; i++) tick();
    #1 check("to_before_err", 32'(mem_err), 32'(1'b0));
    check("to_still_frozen", 32'(ctrl), 32'(C_FRZ));
    tick();
    check("to_mem_err", 32'(mem_err), 32'(1'b1));
    MemReqM = 0;
    #1 check("to_back_run", 32'(ctrl), 32'(C_IDLE));
    check("to_count", 32'(stall_count), 32'd27);
    tick(); tick();
    check("to_sticky", 32'(mem_err), 32'(1'b1));

    // Asynchronous reset mid-wait
    MemReqM = 1;
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'(ctrl), 32'(C_FILL));
    check("arst_mem_err", 32'(mem_err), 32'(1'b0));
    check("arst_count", 32'(stall_count), 32'd0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
